// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default baud divider.
// Optional build macro UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int BIT_CNT_W        = $clog2(DATA_BITS);
  localparam int BAUD_DIV_DEFAULT = 104;   // 12 MHz / 115200

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/baudgen_tx.sv
// Bit-period timer for the UART transmitter. Down-counter that emits a one-cycle
// tick every BAUD_DIV cycles while enabled and reloads whenever it is disabled,
// so each frame starts with a full bit period.
module baudgen_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == '0);

  // Count down to terminal count, reload at each bit boundary and while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, BAUD_DIV clk cycles per bit.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit before stop (8E1).
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | line high, ready=1, waiting for start
//   ST_START  | start bit (tx=0)
//   ST_DATA   | eight data bits, shift register drives tx
//   ST_PARITY | even parity bit (only with UART_TX_PARITY_EN)
//   ST_STOP   | stop bit (tx=1), then back to idle
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shreg;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  baudgen_tx #(.BAUD_DIV(BAUD_DIV)) u_baudgen (
    .clk    (clk),
    .rst    (rst),
    .enable (!ready),
    .tick   (tick)
  );

  // Frame sequencer; tx and ready are flop outputs so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      ready   <= 1'b1;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg   <= data;
            bit_cnt <= LAST_BIT;
            tx      <= 1'b0;
            ready   <= 1'b0;
            state   <= ST_START;
`ifdef UART_TX_PARITY_EN
            par_bit <= ^data;
`endif
          end
        end
        ST_START: begin
          if (tick) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == '0) begin
`ifdef UART_TX_PARITY_EN
              tx    <= par_bit;
              state <= ST_PARITY;
`else
              tx    <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            tx    <= 1'b1;
            ready <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter BAUD_DIV, default 104, clock cycles per serial bit (12 MHz / 115200); legal range 2..65535.
REQ-002 Port clk  input  1  system clock; all logic on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port start  input  1  request to send data; sampled every clk edge.
REQ-005 Port data  input  8  byte to transmit; sampled only on an accepted start.
REQ-006 Port ready  output  1  high when idle and able to accept a byte.
REQ-007 Port tx  output  1  serial line, idle high, registered output.

Function
REQ-008 The block SHALL implement FSM states IDLE, START, DATA, STOP, plus PARITY when UART_TX_PARITY_EN is defined.
REQ-009 In IDLE the block SHALL drive tx=1 and ready=1.
REQ-010 The block SHALL accept a byte when start=1 and ready=1 on the same edge; it SHALL latch data into a shift register on that edge.
REQ-011 The block SHALL ignore start while ready=0, with no effect on the frame in progress.
REQ-012 On the edge after acceptance, ready SHALL be 0, tx SHALL be 0 (start bit), and the state SHALL be START.
REQ-013 Each bit (start, data, parity, stop) SHALL last exactly BAUD_DIV clk cycles, timed by a divider that reloads at every bit boundary.
REQ-014 The block SHALL send data bits LSB first, shifting once per bit boundary.
REQ-015 After 8 data bits, the block SHALL send one stop bit (tx=1).
REQ-016 A frame SHALL be 10*BAUD_DIV cycles, or 11*BAUD_DIV cycles with parity.
REQ-017 At the end of the stop bit, the block SHALL return to IDLE with ready=1 on the following edge.
REQ-018 Back-to-back: a start asserted in the first cycle ready=1 SHALL be accepted, giving a gap of exactly 1 idle cycle at tx=1 between stop and the next start bit.
REQ-019 The divider counter width SHALL be $clog2(BAUD_DIV); the block SHALL produce no glitches on tx because tx is a flop output.

Reset
REQ-020 While rst=1, on each edge the block SHALL set state=IDLE, tx=1, ready=1, clear the divider and bit counters, and clear the shift register.
REQ-021 A reset mid-frame SHALL abort the frame, force tx=1 on the same edge, and discard the byte; start SHALL be ignored while rst=1.

Configuration
REQ-022 With macro UART_TX_PARITY_EN defined, the block SHALL insert one even-parity bit (XOR of the 8 data bits) between the last data bit and the stop bit.
REQ-023 With UART_TX_PARITY_EN undefined, the block SHALL omit the PARITY state and parity logic entirely; timing SHALL follow REQ-016 without parity.

Structure
REQ-024 A shared package uart_pkg SHALL hold the FSM state typedef, the DATA_BITS=8 constant, and the default BAUD_DIV constant, shared with a future receiver.
REQ-025 The baud divider SHALL be a sub-module baudgen_tx (inputs clk, rst, enable; output tick pulsed once every BAUD_DIV cycles while enabled, restarting when enable rises).

Verification (BAUD_DIV=4)
REQ-026 Single byte: rst 2 cycles, then data=0x41 with start for 1 cycle -> tx holds for 4 cycles each of 0,1,0,0,0,0,0,1,0,1; ready=0 for exactly 40 cycles.
REQ-027 Busy start: send 0x41, then pulse start with data=0xFF at cycle 10 -> bit pattern unchanged, no second frame.
REQ-028 Back-to-back: start held high with 0x55 then 0xAA -> two frames separated by exactly 1 idle-high cycle; receiver model decodes 0x55, 0xAA.
REQ-029 Reset mid-frame: assert rst during data bit 3 -> tx=1 and ready=1 the next cycle; a following 0x0F frame is decoded correctly.
REQ-030 Parity build: send 0x41 -> parity bit 0 and frame of 44 cycles; send 0x01 -> parity bit 1.
REQ-031 Idle: 100 cycles without start -> tx constantly 1, ready constantly 1.
